sonar_scheduler: RTL
====================

# sonar_scheduler

Sequencer for the three front ultrasonic sonars. It fires one sonar at a time in round-robin order, measures the echo pulse width in clock cycles, flags timeouts, and enforces a guard interval between pings so that one sensor's echo is never read by another. It sits between the raw sonar pins (trigger out, echo in) and the consumers of the `R1..R3` distance words.

## Interface
- `TRIG_CYCLES`, default 500: trigger pulse width in clk cycles (10 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum wait for the echo rise, and maximum echo width.
- `GUARD_CYCLES`, default 250_000: dead time after each ping.
- `RES_W`, default 20: result width.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: when high, the scheduler keeps pinging.
- `chan_mask` in 3: per-sonar enable. Bit i corresponds to sonar i+1.
- `echo` in 3: raw echo inputs S1..S3. These are asynchronous.
- `trig` out 3: trigger outputs T1..T3. At most one bit is high at a time.
- `R1`, `R2`, `R3` out RES_W: latest result for each sonar.
- `valid` out 3: sticky per sonar. Set on that sonar's first update and cleared only by reset.
- `tout` out 3: per sonar, set when the last ping on that sonar timed out.
- `upd` out 1: one-cycle strobe when any result is written.
- `upd_ch` out 2: index (0..2) of the channel written on the `upd` cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Echo input conditioning**
  - Each `echo` bit passes through a 2-flop synchronizer and then a registered edge detector.
  - Only the synchronized level and its edges are used internally.
- **FSM states:** IDLE, TRIG, WAIT_RISE, MEASURE, GUARD. One shared counter of RES_W bits.
- **IDLE**
  - If `enable` is high and `chan_mask` is nonzero: select the next set mask bit after the last serviced channel, wrapping 2→0, then go to TRIG with the counter at 0.
  - After reset the last serviced channel is 2, so channel 0 is tried first.
- **TRIG**
  - `trig[ch]` is high for exactly TRIG_CYCLES cycles.
  - Then go to WAIT_RISE with the counter at 0.
- **WAIT_RISE**
  - The counter increments every cycle.
  - A synchronized rising edge goes to MEASURE with the counter at 0.
  - If the counter reaches TIMEOUT_CYCLES-1 first: write result all-ones (2^RES_W-1), set `tout[ch]`, go to GUARD.
  - An echo that is already high on entry is not a rise; a stuck-high echo therefore times out.
- **MEASURE**
  - The counter increments every cycle while the synchronized echo is high.
  - On the falling edge: write the result equal to the count, clear `tout[ch]`, go to GUARD.
  - If the count reaches TIMEOUT_CYCLES-1: write all-ones, set `tout[ch]`, go to GUARD.
  - The counter saturates and never wraps.
- **Result write**
  - Updates R[ch], sets `valid[ch]`, pulses `upd` for one cycle with `upd_ch`=ch.
  - Other channels' results are unchanged.
- **GUARD**
  - Wait GUARD_CYCLES cycles, then return to IDLE.
- **Mid-ping changes**
  - `enable` falling mid-ping: the current ping runs to completion, including GUARD, and the FSM then parks in IDLE.
  - `chan_mask` changes: affect only the next selection. A channel cleared mid-ping is still completed.
  - A mask with a single bit set pings that channel repeatedly.
- **Reset (any time, including mid-ping)**
  - `trig`=0 immediately.
  - FSM=IDLE, counter=0.
  - `R1..R3`=0, `valid`=0, `tout`=0, `upd`=0, `upd_ch`=0, `busy`=0.
  - Synchronizer flops=0.

## Timing
- **Trigger start:** the IDLE→TRIG decision is made at edge k. `trig[ch]` is registered and is high from edge k through edge k+TRIG_CYCLES.
- **Rise detection:** a raw echo rise is seen as a rising edge 3 cycles later (2 synchronizer cycles plus 1 edge register).
- **Fall detection:** a raw echo fall has the same 3-cycle latency.
- **Measured value:** the result equals the number of clk cycles the synchronized echo was high. For a clean pulse this is ±1 of the raw width.
- **Write timing:** the result, `upd`, and `tout` are registered the cycle after the falling edge is detected. Raw fall to `upd` is 4 cycles.
- **Ping period** is TRIG_CYCLES + wait + width + GUARD_CYCLES + 2 cycles of state overhead (TRIG entry, GUARD→IDLE).
- **Timeout ping length:** a no-echo ping lasts TRIG_CYCLES + TIMEOUT_CYCLES + GUARD_CYCLES + overhead.
- **Simultaneous edges:** an echo edge in the same cycle as the counter hitting TIMEOUT_CYCLES-1 is resolved as a timeout.

## Structure
- **Package `sonar_pkg`:**
  - `NUM_SONARS`=3 and `RES_W`=20.
  - State enum `sonar_state_t`.
  - `RES_TIMEOUT` = all-ones constant.
- **Sub-module `echo_sync`:**
  - 2-flop synchronizer plus rise/fall edge detect, one bit wide, async active-low reset.
  - Instantiated 3 times.
- **Top level:** the FSM, the counter, the round-robin pointer and the result registers.

## Test plan
Run with TRIG_CYCLES=4, TIMEOUT_CYCLES=200, GUARD_CYCLES=10.

- **Basic round-robin**
  - Stimulus: mask=111, enable=1; each echo rises 20 cycles after its trig falls and stays high 50 cycles.
  - Required: trig order T1,T2,T3,T1, one at a time, each exactly 4 cycles wide.
  - Required: R1=R2=R3=50, `valid`=111, `upd` pulsed once per ping with `upd_ch`=0,1,2.
- **No echo**
  - Stimulus: mask=010, echo[1] held low.
  - Required: R2=0xFFFFF and `tout[1]`=1 after 4+200 cycles plus overhead; T1/T3 never asserted.
- **Long echo**
  - Stimulus: echo[0] high for 300 cycles.
  - Required: R1=0xFFFFF, `tout[0]`=1.
  - Follow-up: next ping with a 30-cycle echo gives R1=30, `tout[0]`=0.
- **Stuck-high echo**
  - Stimulus: echo[2] held high before T3 fires.
  - Required: timeout on channel 2; no MEASURE entry.
- **Enable and mask changes mid-ping**
  - Stimulus: `enable` cleared during MEASURE of channel 1.
  - Required: the ping completes (R2 written, `upd`), GUARD elapses, then `busy`=0 and no further trig.
  - Stimulus: mask changed 111→001 during channel 1's ping.
  - Required: the next trig is T1.
- **Reset mid-operation**
  - Stimulus: assert `reset` low while `trig[0]` is high.
  - Required: `trig`=0 with no clock edge needed; all outputs at reset values.
  - Required: after release, the first ping is on channel 0.

Source files
------------

// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared constants, FSM state type and round-robin helper for the sonar sequencer
package sonar_pkg;

    localparam int NUM_SONARS = 3;
    localparam int RES_W      = 20;

    localparam logic [RES_W-1:0] RES_TIMEOUT = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_GUARD
    } sonar_state_t;

    // First set mask bit strictly after 'last', wrapping 2->0; 'last' itself is the final candidate.
    function automatic logic [1:0] next_chan(input logic [NUM_SONARS-1:0] mask, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (mask[c1]) begin
            return c1;
        end else if (mask[c2]) begin
            return c2;
        end
        return last;
    endfunction

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop synchronizer with registered rise/fall detection for one echo line
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_echo,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_echo;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin trigger/measure/guard sequencer for three ultrasonic sonars
module sonar_scheduler #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned GUARD_CYCLES   = 250_000,
    parameter int unsigned RES_W          = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       chan_mask,
    input  logic [2:0]       echo,
    output logic [2:0]       trig,
    output logic [RES_W-1:0] R1,
    output logic [RES_W-1:0] R2,
    output logic [RES_W-1:0] R3,
    output logic [2:0]       valid,
    output logic [2:0]       tout,
    output logic             upd,
    output logic [1:0]       upd_ch,
    output logic             busy
);
    import sonar_pkg::*;

    localparam logic [RES_W-1:0] CNT_ONE    = RES_W'(1);
    localparam logic [RES_W-1:0] CNT_MAX    = '1;
    localparam logic [RES_W-1:0] TRIG_LAST  = RES_W'(TRIG_CYCLES - 1);
    localparam logic [RES_W-1:0] TO_LAST    = RES_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RES_W-1:0] GUARD_LAST = RES_W'(GUARD_CYCLES - 1);

    sonar_state_t     r_state;
    sonar_state_t     w_state_nx;
    logic [RES_W-1:0] r_cnt;
    logic [RES_W-1:0] w_cnt_nx;
    logic [RES_W-1:0] w_cnt_inc;
    logic [1:0]       r_ch;
    logic [1:0]       w_ch_nx;
    logic [2:0]       r_trig;
    logic [2:0]       w_trig_nx;
    logic [RES_W-1:0] r_res [NUM_SONARS];
    logic [2:0]       r_valid;
    logic [2:0]       r_tout;
    logic             r_upd;
    logic [1:0]       r_upd_ch;
    logic             w_wr;
    logic             w_wr_tout;
    logic [RES_W-1:0] w_wr_val;
    logic [2:0]       w_level;
    logic [2:0]       w_rise;
    logic [2:0]       w_fall;

    for (genvar g = 0; g < NUM_SONARS; g++) begin : g_sync
        echo_sync u_sync (
            .clk     (clk),
            .rst_n   (reset),
            .i_echo  (echo[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ch_nx    = r_ch;
        w_trig_nx  = r_trig;
        w_wr       = 1'b0;
        w_wr_tout  = 1'b0;
        w_wr_val   = '0;
        w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        case (r_state)
            ST_IDLE: begin
                if (enable && (chan_mask != 3'b000)) begin
                    w_ch_nx    = next_chan(chan_mask, r_ch);
                    w_trig_nx  = 3'b001 << w_ch_nx;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_TRIG;
                end
            end
            ST_TRIG: begin
                if (r_cnt == TRIG_LAST) begin
                    w_trig_nx  = 3'b000;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_WAIT_RISE;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_WAIT_RISE: begin
                // Timeout wins over a coincident rise.
                if (r_cnt == TO_LAST) begin
                    w_wr       = 1'b1;
                    w_wr_tout  = 1'b1;
                    w_wr_val   = CNT_MAX;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GUARD;
                end else if (w_rise[r_ch]) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_MEASURE;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_MEASURE: begin
                if (r_cnt == TO_LAST) begin
                    w_wr       = 1'b1;
                    w_wr_tout  = 1'b1;
                    w_wr_val   = CNT_MAX;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GUARD;
                end else if (w_fall[r_ch]) begin
                    // +1 accounts for the high cycle spent detecting the rise in WAIT_RISE.
                    w_wr       = 1'b1;
                    w_wr_val   = w_cnt_inc;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_GUARD;
                end else if (w_level[r_ch]) begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            ST_GUARD: begin
                if (r_cnt == GUARD_LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_trig_nx  = 3'b000;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ch     <= 2'd2;
            r_trig   <= 3'b000;
            r_valid  <= 3'b000;
            r_tout   <= 3'b000;
            r_upd    <= 1'b0;
            r_upd_ch <= 2'd0;
            for (int i = 0; i < NUM_SONARS; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_ch    <= w_ch_nx;
            r_trig  <= w_trig_nx;
            r_upd   <= w_wr;
            if (w_wr) begin
                r_res[r_ch]   <= w_wr_val;
                r_valid[r_ch] <= 1'b1;
                r_tout[r_ch]  <= w_wr_tout;
                r_upd_ch      <= r_ch;
            end
        end
    end

    assign trig   = r_trig;
    assign R1     = r_res[0];
    assign R2     = r_res[1];
    assign R3     = r_res[2];
    assign valid  = r_valid;
    assign tout   = r_tout;
    assign upd    = r_upd;
    assign upd_ch = r_upd_ch;
    assign busy   = (r_state != ST_IDLE);

endmodule
